bdcmotor_channel_gen2: RTL and testbench
========================================

// Module: bdcmotor_channel_gen2
// PURPOSE
//  Parametrised successor brushed-DC motor channel. Combines a filtered quadrature tach counter
//  (CNT_W bits, freeze snapshot, sticky wrap flag) with a PWM_W-bit complementary PWM stage.
//  The PWM stage adds shadowed duty load, a period-latched current limit and dead-time insertion.
//  One instance per motor; bus glue supplies the CE strobes and wrtdata.
// PARAMETERS
//  CNT_W     16  tach counter width (>=8)
//  PWM_W     8   PWM counter/duty width (>=4)
//  FILT_LEN  3   tach filter depth in filterce samples (>=2)
//  DEADTIME  4   clk cycles both outputs stay inactive on every commutation (0 = none)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  reset        in   1       synchronous active-high reset
//  filterce     in   1       tach filter sample enable
//  freeze       in   1       hold count output snapshot (bus read in progress)
//  invphase     in   1       invert count direction
//  clrcount     in   1       zero counter and overflow flag
//  tach         in   2       quadrature inputs {B,A}, asynchronous
//  count        out  CNT_W   tach count (snapshot while freeze=1)
//  overflow     out  1       sticky: counter wrapped in either direction
//  pwmcntce     in   1       PWM counter step enable (sets PWM frequency)
//  pwmldce      in   1       load wrtdata into duty shadow register
//  wrtdata      in   PWM_W   duty value
//  invertpwm    in   1       invert both PWM outputs
//  enablepwm    in   1       0 = both outputs inactive
//  run          in   1       0 = brake
//  currentlimit in   1       terminate current PWM high phase
//  climflag     out  1       high while the current period is limit-terminated
//  pwmout       out  2       {low-side, high-side} drive, registered
// BEHAVIOUR
//  Reset: counter, count, overflow, filters, PWM counter, duty shadow/active, climflag = 0;
//   pwmout = {2{invertpwm}}; dead-time timer loaded with DEADTIME.
//  Tach: 2-flop synchroniser per input; then a FILT_LEN shift register advanced on filterce.
//   Filtered bit changes only when all FILT_LEN samples agree; otherwise it holds.
//  Decode on filtered {B,A} change: 00->01->11->10->00 = +1; reverse = -1; invphase negates.
//   Two-bit jump = no count.
//  Counter arithmetic is mod 2^CNT_W. Wrap max->0 or 0->max sets overflow.
//   clrcount zeroes counter and overflow; clrcount wins over a same-cycle step.
//  count follows counter with 1 clk latency. While freeze=1, count holds its value.
//   Steps during freeze still update the internal counter and appear the cycle after freeze falls.
//  PWM counter: increments on pwmcntce, wraps 2^PWM_W-1 -> 0.
//   Period start = the cycle the counter enters 0.
//  Duty: pwmldce writes the shadow register (last write wins). Shadow copies to active at period start.
//   Same-cycle pwmldce and period start: the new value goes active.
//  Raw drive = (pwmcnt < active_duty) && !climflag. duty=0 gives 0% on; duty=2^PWM_W-1 gives max.
//  currentlimit=1 sets climflag next clk. climflag clears only at period start, and only if
//   currentlimit is low that cycle.
//  Dead-time: on every raw drive change, both sides go inactive for DEADTIME clks.
//   Then the new side turns on. A change during dead time restarts the timer.
//  Mode select, priority high to low:
//   !enablepwm -> both 0
//   !run       -> brake {1,0}, passed through dead-time
//   else       -> {~drive, drive} after dead-time
//  pwmout = mode result XOR {2{invertpwm}}, registered (1 clk after raw drive/dead-time).
//  Both sides are never simultaneously active, in any mode or transition.
// TESTING
//  1. Forward quadrature 8 edges, filterce every clk, FILT_LEN=3 -> count=8. invphase=1, 8 more -> count=0.
//  2. count=0, one reverse step -> count=2^CNT_W-1, overflow=1. clrcount -> count=0, overflow=0.
//  3. freeze=1 then 3 forward steps -> count holds. freeze=0 -> count +3 one clk later.
//  4. duty=64 (PWM_W=8), pwmcntce=1 -> high side 64-DEADTIME clks per 256.
//   Write 128 mid-period -> takes effect only at the next period.
//  5. currentlimit pulse at pwmcnt=10, duty=200 -> high side off, climflag=1 until wrap, normal next period.
//  6. run 1->0 while driving -> DEADTIME clks both off, then {1,0}. enablepwm=0 -> 00.
//   invertpwm=1 -> all levels inverted. No cycle ever has both sides active.

Source files
------------

// File: rtl/bdcmotor_channel_gen2.sv
`default_nettype none
//============================================================================
// Module : bdcmotor_channel_gen2
// Brief  : Brushed-DC motor channel: filtered quadrature tach counter plus a
//          complementary PWM stage with shadowed duty, current limit, dead time.
// Rev    : 1.0  initial release
//============================================================================
module bdcmotor_channel_gen2 #(
    parameter int CNT_W    = 16,
    parameter int PWM_W    = 8,
    parameter int FILT_LEN = 3,
    parameter int DEADTIME = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             filterce,
    input  logic             freeze,
    input  logic             invphase,
    input  logic             clrcount,
    input  logic [1:0]       tach,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             pwmcntce,
    input  logic             pwmldce,
    input  logic [PWM_W-1:0] wrtdata,
    input  logic             invertpwm,
    input  logic             enablepwm,
    input  logic             run,
    input  logic             currentlimit,
    output logic             climflag,
    output logic [1:0]       pwmout
);

    localparam int                c_DT_W    = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
    localparam logic [c_DT_W-1:0] c_DT_LOAD = c_DT_W'(DEADTIME);
    localparam logic [1:0]        c_BRAKE   = 2'b10;

    //------------------------------------------------------------------------
    // Tach input conditioning
    //------------------------------------------------------------------------
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_filt;
    logic [1:0] r_filt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= tach;
            r_sync2 <= r_sync1;
        end
    end

    // Each phase only moves once FILT_LEN consecutive samples agree.
    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic [FILT_LEN-1:0] r_shift;
        logic                r_bit;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_shift <= '0;
                r_bit   <= 1'b0;
            end else begin
                if (filterce) begin
                    r_shift <= {r_shift[FILT_LEN-2:0], r_sync2[gi]};
                end
                if (&r_shift) begin
                    r_bit <= 1'b1;
                end else if (~|r_shift) begin
                    r_bit <= 1'b0;
                end
            end
        end

        assign w_filt[gi] = r_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt_d <= 2'b00;
        end else begin
            r_filt_d <= w_filt;
        end
    end

    // Position along the 00->01->11->10 cycle; difference 1 = forward, 3 = reverse.
    function automatic logic [1:0] f_pos(input logic [1:0] g);
        logic [1:0] p;
        p = 2'd0;
        case (g)
            2'b00:   p = 2'd0;
            2'b01:   p = 2'd1;
            2'b11:   p = 2'd2;
            default: p = 2'd3;
        endcase
        return p;
    endfunction

    logic [1:0] w_diff;
    logic       w_fwd;
    logic       w_rev;
    logic       w_inc;
    logic       w_dec;

    assign w_diff = f_pos(w_filt) - f_pos(r_filt_d);
    assign w_fwd  = (w_diff == 2'd1);
    assign w_rev  = (w_diff == 2'd3);
    assign w_inc  = invphase ? w_rev : w_fwd;
    assign w_dec  = invphase ? w_fwd : w_rev;

    //------------------------------------------------------------------------
    // Tach counter and bus snapshot
    //------------------------------------------------------------------------
    logic [CNT_W-1:0] r_counter;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (reset || clrcount) begin
            r_counter <= '0;
            r_ovf     <= 1'b0;
        end else if (w_inc) begin
            r_counter <= r_counter + 1'b1;
            if (&r_counter) begin
                r_ovf <= 1'b1;
            end
        end else if (w_dec) begin
            r_counter <= r_counter - 1'b1;
            if (~|r_counter) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (!freeze) begin
            r_count <= r_counter;
        end
    end

    assign count    = r_count;
    assign overflow = r_ovf;

    //------------------------------------------------------------------------
    // PWM timebase, duty shadow and current limit
    //------------------------------------------------------------------------
    logic [PWM_W-1:0] r_pwmcnt;
    logic [PWM_W-1:0] r_shadow;
    logic [PWM_W-1:0] r_active;
    logic             r_clim;
    logic             w_wrap;

    assign w_wrap = pwmcntce && (&r_pwmcnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwmcnt <= '0;
            r_shadow <= '0;
            r_active <= '0;
            r_clim   <= 1'b0;
        end else begin
            if (pwmcntce) begin
                r_pwmcnt <= r_pwmcnt + 1'b1;
            end
            if (pwmldce) begin
                r_shadow <= wrtdata;
            end
            // A write landing on the period boundary bypasses the shadow.
            if (w_wrap) begin
                r_active <= pwmldce ? wrtdata : r_shadow;
            end
            if (currentlimit) begin
                r_clim <= 1'b1;
            end else if (w_wrap) begin
                r_clim <= 1'b0;
            end
        end
    end

    assign climflag = r_clim;

    //------------------------------------------------------------------------
    // Dead-time insertion and output mode
    //------------------------------------------------------------------------
    logic              w_drive;
    logic [1:0]        w_req;
    logic [1:0]        r_req;
    logic [c_DT_W-1:0] r_dt;
    logic [c_DT_W-1:0] w_dt_cur;
    logic              w_on;
    logic [1:0]        w_mode;
    logic [1:0]        r_pwmout;

    assign w_drive = (r_pwmcnt < r_active) && !r_clim;
    assign w_req   = run ? {~w_drive, w_drive} : c_BRAKE;

    // The cycle of a request change already counts as the first dead cycle.
    assign w_dt_cur = (w_req != r_req) ? c_DT_LOAD : r_dt;
    assign w_on     = (w_dt_cur == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req <= c_BRAKE;
            r_dt  <= c_DT_LOAD;
        end else begin
            r_req <= w_req;
            r_dt  <= w_on ? '0 : (w_dt_cur - 1'b1);
        end
    end

    always_comb begin
        w_mode = 2'b00;
        if (enablepwm && w_on) begin
            w_mode = w_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwmout <= {2{invertpwm}};
        end else begin
            r_pwmout <= w_mode ^ {2{invertpwm}};
        end
    end

    assign pwmout = r_pwmout;

endmodule
`default_nettype wire

// File: tb/tb_bdcmotor_channel_gen2.sv
`default_nettype none
//============================================================================
// Module : tb_bdcmotor_channel_gen2
// Brief  : Randomised scoreboard bench for bdcmotor_channel_gen2.
// Rev    : 1.0  initial release
//============================================================================
module tb_bdcmotor_channel_gen2;

    localparam int CNT_W    = 16;
    localparam int PWM_W    = 8;
    localparam int FILT_LEN = 3;
    localparam int DEADTIME = 4;
    localparam int CMOD     = 1 << CNT_W;
    localparam int PMOD     = 1 << PWM_W;
    localparam int HOLD     = 12;
    localparam int HOLD_SLOW = 20;

    logic             clk;
    logic             reset;
    logic             filterce;
    logic             freeze;
    logic             invphase;
    logic             clrcount;
    logic [1:0]       tach;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             pwmcntce;
    logic             pwmldce;
    logic [PWM_W-1:0] wrtdata;
    logic             invertpwm;
    logic             enablepwm;
    logic             run;
    logic             currentlimit;
    logic             climflag;
    logic [1:0]       pwmout;

    bdcmotor_channel_gen2 #(
        .CNT_W(CNT_W), .PWM_W(PWM_W), .FILT_LEN(FILT_LEN), .DEADTIME(DEADTIME)
    ) dut (
        .clk(clk), .reset(reset), .filterce(filterce), .freeze(freeze),
        .invphase(invphase), .clrcount(clrcount), .tach(tach), .count(count),
        .overflow(overflow), .pwmcntce(pwmcntce), .pwmldce(pwmldce),
        .wrtdata(wrtdata), .invertpwm(invertpwm), .enablepwm(enablepwm),
        .run(run), .currentlimit(currentlimit), .climflag(climflag),
        .pwmout(pwmout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit               chk_cnt;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic [1:0]       pwm;
        logic             clim;
        logic             inv;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Tach reference: quadrature phase index, true count, visible count.
    int   m_phase, m_cnt, m_vis;
    logic m_ovf;
    // PWM reference.
    int         p_cnt, p_shadow, p_active, p_age;
    bit         p_clim;
    logic [1:0] p_last;
    bit         rnd_pwm, fce_slow;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] gray(input int p);
        logic [1:0] g;
        case (p)
            0:       g = 2'b00;
            1:       g = 2'b01;
            2:       g = 2'b11;
            default: g = 2'b10;
        endcase
        return g;
    endfunction

    // Apply one clock of stimulus, predict the outputs after the edge, advance.
    task automatic cycle(input bit chk_cnt);
        exp_t       e;
        bit         drive, on;
        logic [1:0] req;
        if (rnd_pwm) begin
            pwmcntce     = ($urandom % 8) != 0;
            pwmldce      = ($urandom % 48) == 0;
            wrtdata      = PWM_W'($urandom);
            currentlimit = ($urandom % 300) == 0;
            if ($urandom % 250 == 0) run = ~run;
            if ($urandom % 400 == 0) enablepwm = ~enablepwm;
            if ($urandom % 500 == 0) invertpwm = ~invertpwm;
        end
        filterce = fce_slow ? ~filterce : 1'b1;
        if (reset) begin
            p_cnt = 0; p_shadow = 0; p_active = 0; p_clim = 0;
            p_last = 2'b10; p_age = 0;
            e.pwm  = {2{invertpwm}};
        end else begin
            drive = (p_cnt < p_active) && !p_clim;
            req   = run ? {!drive, drive} : 2'b10;
            if (req != p_last) begin
                p_last = req;
                p_age  = 0;
            end
            on    = p_age >= DEADTIME;
            e.pwm = ((enablepwm && on) ? req : 2'b00) ^ {2{invertpwm}};
            if (p_age < DEADTIME) p_age++;
            if (pwmldce) p_shadow = int'(wrtdata);
            if (pwmcntce && p_cnt == PMOD - 1) begin
                p_active = p_shadow;
                if (!currentlimit) p_clim = 0;
            end
            if (currentlimit) p_clim = 1;
            if (pwmcntce) p_cnt = (p_cnt + 1) % PMOD;
        end
        e.clim    = p_clim;
        e.chk_cnt = chk_cnt;
        e.cnt     = m_vis[CNT_W-1:0];
        e.ovf     = m_ovf;
        e.inv     = invertpwm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic tstep(input int dir, input bit jump, input int hold);
        m_phase = (m_phase + (jump ? 2 : dir) + 4) % 4;
        tach    = gray(m_phase);
        if (!jump) begin
            m_cnt = m_cnt + (invphase ? -dir : dir);
            if (m_cnt < 0) begin
                m_cnt += CMOD; m_ovf = 1'b1;
            end else if (m_cnt >= CMOD) begin
                m_cnt -= CMOD; m_ovf = 1'b1;
            end
        end
        if (!freeze) m_vis = m_cnt;
        for (int i = 0; i < hold; i++) cycle(i == hold - 1);
    endtask

    task automatic glitch(input int len, input int hold);
        logic [1:0] flip;
        flip = ($urandom % 2) ? 2'b01 : 2'b10;
        tach = gray(m_phase) ^ flip;
        for (int i = 0; i < len; i++) cycle(1'b0);
        tach = gray(m_phase);
        for (int i = 0; i < hold; i++) cycle(i == hold - 1);
    endtask

    task automatic clear_count();
        clrcount = 1'b1;
        m_cnt = 0; m_ovf = 1'b0;
        if (!freeze) m_vis = 0;
        cycle(1'b0);
        clrcount = 1'b0;
        cycle(1'b0);
        cycle(1'b1);
    endtask

    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        while (p_cnt != target && n < 2000) begin
            cycle(1'b0);
            n++;
        end
        if (n >= 2000) chk("wait_pwmcnt_timeout", n, 0);
    endtask

    // Scoreboard monitor: one prediction per clock, compared off the active edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pwmout", pwmout, e.pwm);
            chk("climflag", climflag, e.clim);
            chk("shoot_through", ((pwmout ^ {2{e.inv}}) == 2'b11), 0);
            if (e.chk_cnt) begin
                chk("count", count, e.cnt);
                chk("overflow", overflow, e.ovf);
            end
        end
    end

    initial begin : main
        int hi, n;
        reset = 1'b1; filterce = 1'b1; freeze = 1'b0; invphase = 1'b0;
        clrcount = 1'b0; tach = 2'b00; pwmcntce = 1'b0; pwmldce = 1'b0;
        wrtdata = '0; invertpwm = 1'b0; enablepwm = 1'b0; run = 1'b0;
        currentlimit = 1'b0; rnd_pwm = 1'b0; fce_slow = 1'b0;
        m_phase = 0; m_cnt = 0; m_vis = 0; m_ovf = 1'b0;
        p_cnt = 0; p_shadow = 0; p_active = 0; p_clim = 0; p_last = 2'b10; p_age = 0;

        cycle(1'b1); cycle(1'b1);
        invertpwm = 1'b1; cycle(1'b1);
        invertpwm = 1'b0; cycle(1'b1);
        chk("reset_count", count, 0);

        // Duty 64 over period 2, 128 written mid period 2 takes effect in period 3.
        reset = 1'b0; enablepwm = 1'b1; run = 1'b1; pwmcntce = 1'b1;
        hi = 0;
        for (int i = 0; i < 3 * PMOD + 2; i++) begin
            pwmldce = (i == 10) || (i == PMOD + 100);
            wrtdata = (i == 10) ? PWM_W'(64) : PWM_W'(128);
            cycle(1'b0);
            if (pwmout == 2'b01) hi++;
        end
        pwmldce = 1'b0;
        chk("duty_high_clks", hi, (64 - DEADTIME) + (128 - DEADTIME));

        // Current limit at pwmcnt=10 with duty 200.
        pwmldce = 1'b1; wrtdata = PWM_W'(200); cycle(1'b0); pwmldce = 1'b0;
        wait_cnt(0);
        wait_cnt(10);
        currentlimit = 1'b1; cycle(1'b0); currentlimit = 1'b0;
        repeat (7) cycle(1'b0);
        chk("clim_set", climflag, 1);
        chk("clim_off", pwmout, 2'b10);
        wait_cnt(0);
        wait_cnt(20);
        chk("clim_clear", climflag, 0);
        chk("clim_resume", pwmout, 2'b01);

        // Brake while driving, then disable and invert.
        wait_cnt(50);
        run = 1'b0;
        for (int k = 0; k < DEADTIME; k++) begin
            cycle(1'b0);
            chk("brake_dead", pwmout, 2'b00);
        end
        cycle(1'b0);
        chk("brake_on", pwmout, 2'b10);
        enablepwm = 1'b0; cycle(1'b0);
        chk("disabled", pwmout, 2'b00);
        invertpwm = 1'b1; cycle(1'b0);
        chk("disabled_inv", pwmout, 2'b11);
        enablepwm = 1'b1; run = 1'b1;
        repeat (30) cycle(1'b0);
        invertpwm = 1'b0;
        repeat (5) cycle(1'b0);

        // Tach: 8 forward, then 8 forward with inverted phase.
        for (int i = 0; i < 8; i++) tstep(1, 1'b0, HOLD);
        chk("fwd8", count, 8);
        invphase = 1'b1;
        for (int i = 0; i < 8; i++) tstep(1, 1'b0, HOLD);
        chk("inv8", count, 0);
        invphase = 1'b0;
        tstep(-1, 1'b0, HOLD);
        chk("underflow_count", count, CMOD - 1);
        chk("underflow_flag", overflow, 1);
        clear_count();
        chk("clr_flag", overflow, 0);

        freeze = 1'b1;
        for (int i = 0; i < 3; i++) tstep(1, 1'b0, HOLD);
        freeze = 1'b0; m_vis = m_cnt;
        cycle(1'b1);
        chk("freeze_release", count, 3);

        tstep(1, 1'b1, HOLD);
        glitch(1, HOLD);
        glitch(2, HOLD);
        fce_slow = 1'b1;
        for (int i = 0; i < 6; i++) tstep(($urandom % 2) ? 1 : -1, 1'b0, HOLD_SLOW);
        glitch(2, HOLD_SLOW);
        fce_slow = 1'b0; filterce = 1'b1;

        // Combined random traffic on both halves.
        rnd_pwm = 1'b1;
        for (int i = 0; i < 150; i++) begin
            invphase = $urandom % 2;
            freeze   = ($urandom % 5) == 0;
            if (!freeze) m_vis = m_cnt;
            if (i % 40 == 39) clear_count();
            else if ($urandom % 10 == 0) glitch(1 + ($urandom % 2), HOLD);
            else tstep(($urandom % 2) ? 1 : -1, ($urandom % 10) == 0, HOLD);
        end
        rnd_pwm = 1'b0; freeze = 1'b0; m_vis = m_cnt;
        repeat (3) cycle(1'b1);

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
